// File: rtl/gshare_predictor_pkg.sv
// Shared global parameters for the gshare branch predictor: XLEN and default table geometry.
package gshare_predictor_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned BP_IDX_W_DEF = 8;
  localparam int unsigned BP_CNT_W_DEF = 2;
  localparam int unsigned BP_GHR_W_DEF = 8;

endpackage

// File: rtl/gshare_predictor_sat_counter.sv
// Saturating up/down next-value logic for one pattern-table counter.
module bp_sat_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] value,
  input  logic             dir,
  output logic [CNT_W-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (dir && (value != '1)) begin
      next_value = value + CNT_W'(1);
    end else if (!dir && (value != '0)) begin
      next_value = value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor with speculative and committed global histories.
// Optional commit statistics counters are built when macro BP_STATS_EN is defined.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned BP_IDX_W = BP_IDX_W_DEF,
  parameter int unsigned BP_CNT_W = BP_CNT_W_DEF,
  parameter int unsigned BP_GHR_W = BP_GHR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            fet_valid,
  input  logic [XLEN-1:0] fet_pc,
  input  logic            rob_bp_enable,
  input  logic [XLEN-1:0] rob_bp_inst_addr,
  input  logic            rob_bp_jump,
  input  logic            rob_bp_correct,
  output logic            bp_pred,
  output logic [XLEN-1:0] bp_total_cnt,
  output logic [XLEN-1:0] bp_correct_cnt
);

  localparam int unsigned DEPTH = 1 << BP_IDX_W;
  localparam logic [BP_CNT_W-1:0] CNT_INIT = {1'b0, {(BP_CNT_W-1){1'b1}}};

  logic [BP_CNT_W-1:0] r_pht [DEPTH];
  logic [BP_GHR_W-1:0] r_spec_ghr;
  logic [BP_GHR_W-1:0] r_commit_ghr;

  logic [BP_IDX_W-1:0] w_fet_idx;
  logic [BP_IDX_W-1:0] w_com_idx;
  logic [BP_CNT_W-1:0] w_cnt_next;
  logic                w_accept_commit;
  logic                w_unused;

  assign w_fet_idx       = fet_pc[BP_IDX_W:1] ^ BP_IDX_W'(r_spec_ghr);
  assign w_com_idx       = rob_bp_inst_addr[BP_IDX_W:1] ^ BP_IDX_W'(r_commit_ghr);
  assign w_accept_commit = rdy && !rst && !flush && rob_bp_enable;

  // Table is read before this cycle's commit write lands, so a same-entry fetch sees the old count.
  assign bp_pred = r_pht[w_fet_idx][BP_CNT_W-1];

  bp_sat_counter #(
    .CNT_W (BP_CNT_W)
  ) u_sat (
    .value      (r_pht[w_com_idx]),
    .dir        (rob_bp_jump),
    .next_value (w_cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_pht[BP_IDX_W'(i)] <= CNT_INIT;
        end
        r_spec_ghr   <= '0;
        r_commit_ghr <= '0;
      end else if (flush) begin
        r_spec_ghr <= r_commit_ghr;
      end else begin
        if (fet_valid) begin
          r_spec_ghr <= BP_GHR_W'({r_spec_ghr, bp_pred});
        end
        if (rob_bp_enable) begin
          r_pht[w_com_idx] <= w_cnt_next;
          r_commit_ghr     <= BP_GHR_W'({r_commit_ghr, rob_bp_jump});
        end
      end
    end
  end

`ifdef BP_STATS_EN
  logic [XLEN-1:0] r_total_cnt;
  logic [XLEN-1:0] r_correct_cnt;

  always_ff @(posedge clk) begin
    if (rdy && rst) begin
      r_total_cnt   <= '0;
      r_correct_cnt <= '0;
    end else if (w_accept_commit) begin
      r_total_cnt <= r_total_cnt + XLEN'(1);
      if (rob_bp_correct) begin
        r_correct_cnt <= r_correct_cnt + XLEN'(1);
      end
    end
  end

  assign bp_total_cnt   = r_total_cnt;
  assign bp_correct_cnt = r_correct_cnt;
`else
  assign bp_total_cnt   = '0;
  assign bp_correct_cnt = '0;
`endif

  // Address bits outside the index window do not participate in prediction.
  assign w_unused = ^{fet_pc[0], fet_pc[XLEN-1:BP_IDX_W+1],
                      rob_bp_inst_addr[0], rob_bp_inst_addr[XLEN-1:BP_IDX_W+1],
                      rob_bp_correct, w_accept_commit};

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter BP_IDX_W, default 8, meaning pattern table index width (table depth 2^BP_IDX_W).
REQ-002 SHALL have parameter BP_CNT_W, default 2, meaning saturating counter width (legal range 2..4).
REQ-003 SHALL have parameter BP_GHR_W, default 8, meaning global history width (legal range 1..BP_IDX_W).
REQ-004 SHALL have port clk, input, 1, meaning clock.
REQ-005 SHALL have port rst, input, 1, meaning reset; reset rst, synchronous, active-high; clock clk.
REQ-006 SHALL have port rdy, input, 1, meaning global enable; all state holds while low.
REQ-007 SHALL have port flush, input, 1, meaning pipeline flush after a mispredict.
REQ-008 SHALL have port fet_valid, input, 1, meaning the fetcher consumes a conditional-branch prediction this cycle.
REQ-009 SHALL have port fet_pc, input, XLEN, meaning fetch instruction address.
REQ-010 SHALL have port rob_bp_enable, input, 1, meaning a conditional branch commits this cycle.
REQ-011 SHALL have port rob_bp_inst_addr, input, XLEN, meaning committing branch address.
REQ-012 SHALL have port rob_bp_jump, input, 1, meaning the committing branch was taken.
REQ-013 SHALL have port rob_bp_correct, input, 1, meaning the committing branch was predicted correctly.
REQ-014 SHALL have port bp_pred, output, 1, meaning predicted taken.
REQ-015 SHALL have port bp_total_cnt, output, XLEN, meaning committed branch count.
REQ-016 SHALL have port bp_correct_cnt, output, XLEN, meaning correctly predicted branch count.

Function
REQ-017 Fetch index SHALL be fet_pc[BP_IDX_W:1] XOR spec_ghr, with spec_ghr zero-extended to BP_IDX_W.
REQ-018 bp_pred SHALL be the counter MSB at the fetch index, combinational, valid in the same cycle as fet_pc.
REQ-019 On rdy && !flush && fet_valid, spec_ghr SHALL shift left by one and take bp_pred into bit 0.
REQ-020 Commit index SHALL be rob_bp_inst_addr[BP_IDX_W:1] XOR commit_ghr (pre-update value); with in-order commit this equals the fetch-time index.
REQ-021 On rdy && !flush && rob_bp_enable, the indexed counter SHALL increment if rob_bp_jump and decrement otherwise, saturating at all-ones and zero.
REQ-022 Under the same condition, commit_ghr SHALL shift left and take rob_bp_jump into bit 0.
REQ-023 On rdy && flush, spec_ghr SHALL load the current commit_ghr, and no counter, commit_ghr or statistics update SHALL occur that cycle.
REQ-024 When a fetch and a commit hit the same entry in one cycle, bp_pred SHALL reflect the pre-update counter value.
REQ-025 Simultaneous fet_valid and rob_bp_enable SHALL both take effect (independent histories).

Reset
REQ-026 On rdy && rst, every counter SHALL become 2^(BP_CNT_W-1)-1 (weakly not-taken), both histories SHALL become 0, and both statistics counters SHALL become 0.
REQ-027 After reset, bp_pred SHALL be 0 for every fet_pc.
REQ-028 rst SHALL take priority over flush, fet_valid and rob_bp_enable.

Configuration
REQ-029 With macro BP_STATS_EN defined, bp_total_cnt SHALL increment on each accepted commit, and bp_correct_cnt SHALL increment when rob_bp_correct is also high; both SHALL wrap modulo 2^XLEN.
REQ-030 Without BP_STATS_EN, bp_total_cnt and bp_correct_cnt SHALL be constant 0 and no statistics registers SHALL exist.

Structure
REQ-031 XLEN and the default values of BP_IDX_W, BP_CNT_W and BP_GHR_W SHALL live in the shared global_params header.
REQ-032 The saturating next-value logic SHALL be a sub-module, bp_sat_counter (inputs: value, dir; output: next value), instantiated once on the commit path.

Verification
REQ-033 Reset, then fet_pc=0x100 -> bp_pred=0, and every counter reads 01.
REQ-034 Commit 0x100 taken with commit_ghr=0x00 -> entry 0x80 becomes 10 and commit_ghr=0x01; then flush -> spec_ghr=0x01; then fet_pc=0x102 -> index 0x80, bp_pred=1.
REQ-035 Four taken commits to one entry with histories held by rst-free flushes -> counter saturates at 11; one not-taken commit -> counter is 10 and bp_pred stays 1.
REQ-036 Three fet_valid cycles with bp_pred=1 -> spec_ghr=0x07; then flush with commit_ghr=0x00 -> spec_ghr=0x00.
REQ-037 flush together with rob_bp_enable -> counter, commit_ghr and statistics unchanged; rdy=0 for 5 cycles with active inputs -> all state unchanged.
REQ-038 With BP_STATS_EN, 3 commits of which 2 are correct -> bp_total_cnt=3 and bp_correct_cnt=2; without BP_STATS_EN -> both read 0.
